mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 100 ++++++++++
 tb/tb_mem_access_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Requester-side controller for a 16-byte edge-strobed memory.
// Each transaction runs IDLE -> SETUP -> STROBE (STROBE_CYC clocks) -> HOLD -> IDLE.
// Address and data are set up one clock before the strobe rises and held one clock after it falls.
module mem_access_ctrl #(
  parameter int unsigned STROBE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_read,
  output logic       mem_write,
  input  logic [7:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] CNT_INIT = 4'(STROBE_CYC);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       op;
  logic       accept;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && (state == IDLE);

  // State and strobe down-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; the counter is loaded on SETUP->STROBE and exits STROBE on its last count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = SETUP;
      end
      SETUP: begin
        state_nxt = STROBE;
        cnt_nxt   = CNT_INIT;
      end
      STROBE: begin
        if (cnt <= 4'd1) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HOLD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Datapath: request capture, registered strobes and response generation.
  // Strobes are registered from state_nxt so they rise and fall on the same edges as the STROBE state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      op         <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
        op        <= req_write;
      end
      mem_read   <= (state_nxt == STROBE) && !op;
      mem_write  <= (state_nxt == STROBE) && op;
      resp_valid <= (state == HOLD);
      if ((state == HOLD) && !op) resp_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl: one instance at STROBE_CYC=1, one at STROBE_CYC=3,
// each attached to a behavioural edge-strobed 16-byte memory.
module tb_mem_access_ctrl;

  localparam int N1 = 1;
  localparam int N3 = 3;

  logic clk;
  logic rst_n;

  logic       req_valid, req_ready, req_write;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_read, mem_write;
  logic [7:0] mem_rdata;

  logic       req_valid3, req_ready3, req_write3;
  logic [3:0] req_addr3;
  logic [7:0] req_wdata3;
  logic       resp_valid3;
  logic [7:0] resp_rdata3;
  logic [3:0] mem_addr3;
  logic [7:0] mem_wdata3;
  logic       mem_read3, mem_write3;
  logic [7:0] mem_rdata3;

  int vectors;
  int miscompares;
  int resp_cnt;

  logic [7:0] mem1 [16];
  logic [7:0] mem3 [16];
  logic [7:0] exp_mem [16];
  logic [7:0] last_rd1;

  mem_access_ctrl dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  mem_access_ctrl #(.STROBE_CYC(N3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write3),
    .req_addr(req_addr3), .req_wdata(req_wdata3),
    .resp_valid(resp_valid3), .resp_rdata(resp_rdata3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_read(mem_read3), .mem_write(mem_write3), .mem_rdata(mem_rdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge-strobed memories; read data goes unknown while a write strobe fires.
  always @(posedge mem_write) begin
    mem1[mem_addr] <= mem_wdata;
    mem_rdata      <= 'x;
  end
  always @(posedge mem_read) mem_rdata <= mem1[mem_addr];

  always @(posedge mem_write3) begin
    mem3[mem_addr3] <= mem_wdata3;
    mem_rdata3      <= 'x;
  end
  always @(posedge mem_read3) mem_rdata3 <= mem3[mem_addr3];

  always @(negedge clk) if (resp_valid === 1'b1) resp_cnt++;

  // One transaction on dut1, entered and left at a falling edge.
  // j counts rising edges after the acceptance edge.
  task automatic txn(input logic wr, input logic [3:0] a, input logic [7:0] d, input bit scr);
    logic [7:0] exp_rd;
    logic strb, other, exp_s, exp_r;
    exp_rd = wr ? last_rd1 : exp_mem[a];
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL txn_ready_idle: req_ready=%b want 1", req_ready);
    end
    @(posedge clk); @(negedge clk);
    for (int j = 0; j <= N1 + 2; j++) begin
      strb  = wr ? mem_write : mem_read;
      other = wr ? mem_read : mem_write;
      exp_s = (j >= 1) && (j <= N1);
      exp_r = (j == N1 + 2);
      vectors++;
      if (strb !== exp_s) begin
        miscompares++; $display("FAIL txn_strobe j=%0d wr=%b: got %b want %b", j, wr, strb, exp_s);
      end
      vectors++;
      if (other !== 1'b0) begin
        miscompares++; $display("FAIL txn_other_strobe j=%0d: got %b want 0", j, other);
      end
      vectors++;
      if (mem_addr !== a || mem_wdata !== d) begin
        miscompares++;
        $display("FAIL txn_addr_data j=%0d: got %h/%h want %h/%h", j, mem_addr, mem_wdata, a, d);
      end
      vectors++;
      if (resp_valid !== exp_r || req_ready !== exp_r) begin
        miscompares++;
        $display("FAIL txn_resp_ready j=%0d: got %b/%b want %b/%b", j, resp_valid, req_ready, exp_r, exp_r);
      end
      if (j == N1 + 2) begin
        vectors++;
        if (resp_rdata !== exp_rd) begin
          miscompares++; $display("FAIL txn_rdata addr=%h wr=%b: got %h want %h", a, wr, resp_rdata, exp_rd);
        end
      end else begin
        if (scr) begin
          req_valid = 1'b1; req_write = ~wr; req_addr = ~a; req_wdata = ~d;
        end else begin
          req_valid = 1'b0;
        end
        @(posedge clk); @(negedge clk);
      end
    end
    req_valid = 1'b0;
    if (wr) exp_mem[a] = d;
    else    last_rd1 = exp_rd;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    vectors++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: rd=%b wr=%b rv=%b want 0/0/0", mem_read, mem_write, resp_valid);
    end
    vectors++;
    if (mem_addr !== 4'h0 || mem_wdata !== 8'h00 || resp_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0/00/00", mem_addr, mem_wdata, resp_rdata);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || req_ready3 !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready: got %b/%b want 1/1", req_ready, req_ready3);
    end
    @(negedge clk);
  endtask

  task automatic test_write_read;
    txn(1'b1, 4'h3, 8'hA5, 1'b0);
    txn(1'b0, 4'h3, 8'h00, 1'b0);
  endtask

  task automatic test_strobe3;
    int hi;
    hi = 0;
    mem3[15] = 8'h5C;
    req_valid3 = 1'b1; req_write3 = 1'b0; req_addr3 = 4'hF; req_wdata3 = 8'h00;
    vectors++;
    if (req_ready3 !== 1'b1) begin
      miscompares++; $display("FAIL s3_ready: got %b want 1", req_ready3);
    end
    @(posedge clk); @(negedge clk);
    req_valid3 = 1'b0;
    for (int j = 0; j <= N3 + 2; j++) begin
      if (mem_read3 === 1'b1) hi++;
      vectors++;
      if (mem_read3 !== ((j >= 1) && (j <= N3)) || mem_write3 !== 1'b0) begin
        miscompares++; $display("FAIL s3_strobe j=%0d: rd=%b wr=%b", j, mem_read3, mem_write3);
      end
      vectors++;
      if (resp_valid3 !== (j == N3 + 2)) begin
        miscompares++; $display("FAIL s3_resp j=%0d: got %b want %b", j, resp_valid3, (j == N3 + 2));
      end
      if (j == N3 + 2) begin
        vectors++;
        if (resp_rdata3 !== 8'h5C) begin
          miscompares++; $display("FAIL s3_rdata: got %h want 5c", resp_rdata3);
        end
      end else begin
        @(posedge clk); @(negedge clk);
      end
    end
    vectors++;
    if (hi != N3) begin
      miscompares++; $display("FAIL s3_strobe_width: got %0d want %0d", hi, N3);
    end
  endtask

  task automatic test_back_to_back;
    logic       wr_seq [6];
    logic [7:0] d_seq [6];
    logic [7:0] rd_exp [3];
    int acc_t [8];
    int n_acc, n_resp, idx;
    bit acc_now;
    wr_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    d_seq  = '{8'h11, 8'h00, 8'h22, 8'h00, 8'h33, 8'h00};
    rd_exp = '{8'h11, 8'h22, 8'h33};
    n_acc = 0; n_resp = 0; idx = 0; acc_now = 1'b0;
    req_valid = 1'b1; req_write = wr_seq[0]; req_addr = 4'h0; req_wdata = d_seq[0];
    for (int t = 0; t < 40; t++) begin
      if (req_valid && req_ready === 1'b1) begin
        if (n_acc < 8) acc_t[n_acc] = t;
        n_acc++;
        acc_now = 1'b1;
      end
      vectors++;
      if (mem_read === 1'b1 && mem_write === 1'b1) begin
        miscompares++; $display("FAIL b2b_overlap t=%0d: rd=%b wr=%b", t, mem_read, mem_write);
      end
      if (resp_valid === 1'b1) begin
        if (n_resp % 2 == 1) begin
          vectors++;
          if (resp_rdata !== rd_exp[n_resp / 2]) begin
            miscompares++;
            $display("FAIL b2b_rdata k=%0d: got %h want %h", n_resp, resp_rdata, rd_exp[n_resp / 2]);
          end
        end
        n_resp++;
      end
      @(negedge clk);
      if (acc_now) begin
        acc_now = 1'b0;
        idx++;
        if (idx < 6) begin
          req_write = wr_seq[idx]; req_wdata = d_seq[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    vectors++;
    if (n_acc != 6 || n_resp != 6) begin
      miscompares++; $display("FAIL b2b_counts: acc=%0d resp=%0d want 6/6", n_acc, n_resp);
    end
    for (int k = 1; k < 6 && k < n_acc; k++) begin
      vectors++;
      if (acc_t[k] - acc_t[k-1] != N1 + 3) begin
        miscompares++;
        $display("FAIL b2b_spacing k=%0d: got %0d want %0d", k, acc_t[k] - acc_t[k-1], N1 + 3);
      end
    end
    exp_mem[0] = 8'h33;
    last_rd1 = 8'h33;
  endtask

  task automatic test_busy_ignore;
    txn(1'b1, 4'h9, 8'h3C, 1'b1);
    txn(1'b0, 4'h9, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid_strobe;
    int snap;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h7; req_wdata = 8'h99;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (mem_write !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_pre: mem_write=%b want 1", mem_write);
    end
    snap = resp_cnt;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_strobe: wr=%b rd=%b rv=%b want 0/0/0", mem_write, mem_read, resp_valid);
    end
    vectors++;
    if (mem_addr !== 4'h0 || mem_wdata !== 8'h00 || resp_rdata !== 8'h00 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_values: addr=%h wdata=%h rdata=%h rdy=%b", mem_addr, mem_wdata, resp_rdata, req_ready);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    vectors++;
    if (resp_cnt != snap || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_after: resp pulses=%0d want 0, rdy=%b want 1", resp_cnt - snap, req_ready);
    end
    exp_mem[7] = 8'h99;
    last_rd1 = 8'h00;
    txn(1'b0, 4'h3, 8'h00, 1'b0);
  endtask

  task automatic test_all_addrs;
    int snap;
    snap = resp_cnt;
    for (int i = 0; i < 16; i++) txn(1'b1, 4'(i), 8'(i * 17 + 3), 1'b0);
    vectors++;
    if (resp_cnt - snap != 16) begin
      miscompares++; $display("FAIL all_wr_pulses: got %0d want 16", resp_cnt - snap);
    end
    snap = resp_cnt;
    for (int i = 0; i < 16; i++) txn(1'b0, 4'(i), 8'h00, 1'b0);
    vectors++;
    if (resp_cnt - snap != 16) begin
      miscompares++; $display("FAIL all_rd_pulses: got %0d want 16", resp_cnt - snap);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; resp_cnt = 0;
    last_rd1 = 8'h00;
    for (int i = 0; i < 16; i++) begin
      mem1[i] = 8'h00; mem3[i] = 8'h00; exp_mem[i] = 8'h00;
    end
    req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0; req_wdata = 8'h00;
    req_valid3 = 1'b0; req_write3 = 1'b0; req_addr3 = 4'h0; req_wdata3 = 8'h00;
    test_reset;
    test_write_read;
    test_strobe3;
    test_back_to_back;
    test_busy_ignore;
    test_reset_mid_strobe;
    test_all_addrs;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
